// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate decoder with a small skid buffer on the output.
// Define IMM_GEN_ZICSR_EN to decode SYSTEM (CSR) instructions as legal.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [XLEN-1:0] imm_q [DEPTH];
    logic [2:0]      fmt_q [DEPTH];
    logic            ill_q [DEPTH];
    logic [XLEN-1:0] pc_q  [DEPTH];

    logic            push, pop;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];

    always_comb begin
        dec_imm = '0;
        dec_fmt = 3'd0;
        dec_ill = 1'b0;
        unique case (opcode)
            7'b0010011: begin
                dec_fmt = 3'd1;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // shamt width follows XLEN; funct7 stays out of the immediate
                    if (XLEN == 64)
                        dec_imm = zext({26'b0, in_inst[25:20]});
                    else
                        dec_imm = zext({27'b0, in_inst[24:20]});
                end else begin
                    dec_imm = sext({{20{in_inst[31]}}, in_inst[31:20]});
                end
            end
            7'b0000011, 7'b1100111: begin
                dec_fmt = 3'd1;
                dec_imm = sext({{20{in_inst[31]}}, in_inst[31:20]});
            end
            7'b0100011: begin
                dec_fmt = 3'd2;
                dec_imm = sext({{20{in_inst[31]}}, in_inst[31:25],
                                in_inst[11:7]});
            end
            7'b1100011: begin
                dec_fmt = 3'd3;
                dec_imm = sext({{20{in_inst[31]}}, in_inst[7],
                                in_inst[30:25], in_inst[11:8], 1'b0});
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = 3'd4;
                dec_imm = sext({in_inst[31:12], 12'b0});
            end
            7'b1101111: begin
                dec_fmt = 3'd5;
                dec_imm = sext({{12{in_inst[31]}}, in_inst[19:12],
                                in_inst[20], in_inst[30:21], 1'b0});
            end
            7'b0110011: begin
                dec_fmt = 3'd0;
            end
`ifdef IMM_GEN_ZICSR_EN
            7'b1110011: begin
                unique case (funct3)
                    3'b101, 3'b110, 3'b111: begin
                        dec_fmt = 3'd6;
                        dec_imm = zext({27'b0, in_inst[19:15]});
                    end
                    3'b001, 3'b010, 3'b011: begin
                        dec_fmt = 3'd1;
                        dec_imm = zext({20'b0, in_inst[31:20]});
                    end
                    3'b000:  dec_fmt = 3'd0;
                    default: dec_ill = 1'b1;
                endcase
            end
`else
            7'b1110011: dec_ill = 1'b1;
`endif
            default: dec_ill = 1'b1;
        endcase
    end

    // in_ready depends only on registered occupancy
    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (push) tail_d = ptr_inc(tail_q);
            if (pop)  head_d = ptr_inc(head_q);
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= '0;
                ill_q[i] <= 1'b0;
                pc_q[i]  <= '0;
            end
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            if (push && !flush) begin
                imm_q[tail_q] <= dec_imm;
                fmt_q[tail_q] <= dec_fmt;
                ill_q[tail_q] <= dec_ill;
                pc_q[tail_q]  <= in_pc;
            end
        end
    end

    assign out_imm     = out_valid ? imm_q[head_q] : '0;
    assign out_fmt     = out_valid ? fmt_q[head_q] : 3'd0;
    assign out_illegal = out_valid ? ill_q[head_q] : 1'b0;
    assign out_pc      = out_valid ? pc_q[head_q]  : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: 32-bit two-entry and 64-bit single-entry builds.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid, out_ready, out_illegal;
    logic [31:0] out_imm, out_pc;
    logic [2:0]  out_fmt;

    logic        w_in_valid, w_in_ready, w_flush;
    logic [31:0] w_in_inst;
    logic [63:0] w_in_pc;
    logic        w_out_valid, w_out_ready, w_out_illegal;
    logic [63:0] w_out_imm, w_out_pc;
    logic [2:0]  w_out_fmt;

    int n_vec = 0;
    int n_bad = 0;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal), .out_pc(out_pc)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(1)) u64 (
        .clk(clk), .reset(reset),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_inst(w_in_inst), .in_pc(w_in_pc), .flush(w_flush),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_imm(w_out_imm), .out_fmt(w_out_fmt),
        .out_illegal(w_out_illegal), .out_pc(w_out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0};
        tbl[1]  = '{32'hFE20AE23, 32'hFFFFFFFC, 3'd2, 1'b0};
        tbl[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0};
        tbl[3]  = '{32'h123452B7, 32'h12345000, 3'd4, 1'b0};
        tbl[4]  = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0};
        tbl[5]  = '{32'h01F09093, 32'h0000001F, 3'd1, 1'b0};
        tbl[6]  = '{32'h4030D093, 32'h00000003, 3'd1, 1'b0};
        tbl[7]  = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1};
        tbl[8]  = '{32'hFFC12083, 32'hFFFFFFFC, 3'd1, 1'b0};
        tbl[9]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0};
        tbl[10] = '{32'h80008067, 32'hFFFFF800, 3'd1, 1'b0};
        tbl[11] = '{32'hFFFFF017, 32'hFFFFF000, 3'd4, 1'b0};
`ifdef IMM_GEN_ZICSR_EN
        tbl[12] = '{32'h3400D073, 32'h00000001, 3'd6, 1'b0};
        tbl[13] = '{32'h30029073, 32'h00000300, 3'd1, 1'b0};
        tbl[14] = '{32'h00000073, 32'h00000000, 3'd0, 1'b0};
        tbl[15] = '{32'h0000C073, 32'h00000000, 3'd0, 1'b1};
`else
        tbl[12] = '{32'h3400D073, 32'h00000000, 3'd0, 1'b1};
        tbl[13] = '{32'h30029073, 32'h00000000, 3'd0, 1'b1};
        tbl[14] = '{32'h00000073, 32'h00000000, 3'd0, 1'b1};
        tbl[15] = '{32'h0000C073, 32'h00000000, 3'd0, 1'b1};
`endif

        reset = 1'b1;
        in_valid = 0; in_inst = '0; in_pc = '0; flush = 0; out_ready = 1;
        w_in_valid = 0; w_in_inst = '0; w_in_pc = '0; w_flush = 0;
        w_out_ready = 1;
        #12;
        chk("rst_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_imm", {32'b0, out_imm}, 64'd0);
        chk("rst_pc", {32'b0, out_pc}, 64'd0);
        reset = 1'b0;
        tick();

        // streaming table: one push per cycle, previous entry pops
        for (int i = 0; i < 16; i++) begin
            in_valid = 1;
            in_inst  = tbl[i].inst;
            in_pc    = 32'h1000 + 32'(i * 4);
            tick();
            chk($sformatf("v%0d_valid", i), {63'b0, out_valid}, 64'd1);
            chk($sformatf("v%0d_imm", i), {32'b0, out_imm}, {32'b0, tbl[i].imm});
            chk($sformatf("v%0d_fmt", i), {61'b0, out_fmt}, {61'b0, tbl[i].fmt});
            chk($sformatf("v%0d_ill", i), {63'b0, out_illegal}, {63'b0, tbl[i].ill});
            chk($sformatf("v%0d_pc", i), {32'b0, out_pc},
                64'h1000 + 64'(i * 4));
        end
        in_valid = 0;
        tick();
        chk("drain_valid", {63'b0, out_valid}, 64'd0);

        // stall: three offers against a blocked consumer
        out_ready = 0;
        in_valid = 1; in_inst = 32'h00100093; in_pc = 32'hA0;
        tick();
        in_inst = 32'h00200093; in_pc = 32'hA4;
        chk("st_head0", {32'b0, out_imm}, 64'd1);
        tick();
        in_inst = 32'h00300093; in_pc = 32'hA8;
        chk("st_full", {63'b0, in_ready}, 64'd0);
        chk("st_head1", {32'b0, out_imm}, 64'd1);
        tick();
        chk("st_head2", {32'b0, out_imm}, 64'd1);
        chk("st_pc2", {32'b0, out_pc}, 64'hA0);
        chk("st_full2", {63'b0, in_ready}, 64'd0);
        out_ready = 1;
        tick();
        chk("st_dr1", {32'b0, out_imm}, 64'd2);
        chk("st_rdy", {63'b0, in_ready}, 64'd1);
        tick();
        in_valid = 0;
        chk("st_dr2", {32'b0, out_imm}, 64'd3);
        chk("st_dr2pc", {32'b0, out_pc}, 64'hA8);
        tick();
        chk("st_empty", {63'b0, out_valid}, 64'd0);

        // flush with two entries held and an offer pending
        out_ready = 0;
        in_valid = 1; in_inst = 32'h00400093;
        tick();
        in_inst = 32'h00500093;
        tick();
        chk("fl_full", {63'b0, in_ready}, 64'd0);
        in_inst = 32'h00600093; flush = 1;
        tick();
        flush = 0; in_valid = 0; out_ready = 1;
        chk("fl_valid", {63'b0, out_valid}, 64'd0);
        chk("fl_ready", {63'b0, in_ready}, 64'd1);
        tick();
        chk("fl_stay", {63'b0, out_valid}, 64'd0);

        // flush with one entry held and an accepted push discarded
        out_ready = 0;
        in_valid = 1; in_inst = 32'h00700093;
        tick();
        in_inst = 32'h00800093; flush = 1;
        tick();
        flush = 0; in_valid = 0; out_ready = 1;
        chk("fl1_valid", {63'b0, out_valid}, 64'd0);
        tick();
        chk("fl1_stay", {63'b0, out_valid}, 64'd0);

        // asynchronous reset mid-stream
        out_ready = 0;
        in_valid = 1; in_inst = 32'hFFF00093; in_pc = 32'hBEEF;
        tick();
        in_valid = 0;
        chk("ar_pre", {32'b0, out_imm}, 64'hFFFFFFFF);
        #2 reset = 1;
        #1;
        chk("ar_valid", {63'b0, out_valid}, 64'd0);
        chk("ar_imm", {32'b0, out_imm}, 64'd0);
        chk("ar_fmt", {61'b0, out_fmt}, 64'd0);
        chk("ar_pc", {32'b0, out_pc}, 64'd0);
        #3 reset = 0;
        out_ready = 1;
        tick();
        chk("ar_lost", {63'b0, out_valid}, 64'd0);

        // 64-bit, single entry: no skid, wide shamt and sign extension
        w_in_valid = 1; w_in_inst = 32'h03F09093;
        w_in_pc = 64'h8000_0000_0000_0010;
        tick();
        w_in_inst = 32'hFFF00093; w_in_pc = 64'h8000_0000_0000_0014;
        chk("w_imm_sh", w_out_imm, 64'h3F);
        chk("w_fmt_sh", {61'b0, w_out_fmt}, 64'd1);
        chk("w_pc_sh", w_out_pc, 64'h8000_0000_0000_0010);
        chk("w_full", {63'b0, w_in_ready}, 64'd0);
        tick();
        chk("w_gap", {63'b0, w_out_valid}, 64'd0);
        chk("w_rdy", {63'b0, w_in_ready}, 64'd1);
        tick();
        w_in_valid = 0;
        chk("w_imm_neg", w_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("w_pc_neg", w_out_pc, 64'h8000_0000_0000_0014);
        tick();
        chk("w_empty", {63'b0, w_out_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
